rstatus_queue: RTL and testbench
================================

RSTATUS_QUEUE -- requirements
Module: rstatus_queue

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of status word written to $rstatus.
REQ-002 SHALL have parameter DEPTH, default 4: pending-status queue depth, power of two, >= 2.
REQ-003 SHALL have parameter RS_ADDR, default 30: register-file index of $rstatus.
REQ-004 SHALL have port clock, input, 1: single clock, all state on rising edge.
REQ-005 SHALL have port reset, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port ex_valid, input, 1: execute-stage instruction valid.
REQ-007 SHALL have port ex_op, input, 5: execute-stage opcode.
REQ-008 SHALL have port ex_alu_op, input, 5: execute-stage ALU op field.
REQ-009 SHALL have port ex_ovf, input, 1: ALU overflow for the execute-stage instruction.
REQ-010 SHALL have port flush, input, 1: kill execute-stage instruction this cycle.
REQ-011 SHALL have port md_done, input, 1: multdiv result completes this cycle.
REQ-012 SHALL have port md_is_div, input, 1: completing multdiv op is div (else mult).
REQ-013 SHALL have port md_exc, input, 1: multdiv overflow / divide-by-zero.
REQ-014 SHALL have port rs_valid, output, 1: status write pending.
REQ-015 SHALL have port rs_ready, input, 1: writeback accepts the status write.
REQ-016 SHALL have port rs_addr, output, 5: constant RS_ADDR.
REQ-017 SHALL have port rs_data, output, DATA_W: status value, zero-extended code.
REQ-018 SHALL have port stall, output, 1: front end must hold new ALU/multdiv issue.
REQ-019 SHALL have port lost, output, 1: sticky flag, an event was dropped.

Function
REQ-020 Codes SHALL be: addi (op 00101) = 1, add (op 00000, alu 00000) = 2, sub (op 00000, alu 00001) = 3, mult = 4, div = 5.
REQ-021 ALU event SHALL be ex_valid & ex_ovf & !flush & (addi|add|sub); other ops with ex_ovf produce no event.
REQ-022 Multdiv event SHALL be md_done & md_exc, code 5 if md_is_div else 4.
REQ-023 Events SHALL be pushed into a FIFO of DEPTH entries; in a simultaneous push the multdiv event SHALL be enqueued ahead of the ALU event.
REQ-024 rs_valid SHALL be high exactly when the FIFO is non-empty; rs_data SHALL be the head code, registered, stable while rs_valid & !rs_ready.
REQ-025 Pop SHALL occur on rs_valid & rs_ready; next head SHALL be presented the following cycle with no bubble.
REQ-026 Push latency SHALL be one cycle: an event at edge N gives rs_valid at N+1 when the FIFO was empty.
REQ-027 Pop and push in the same cycle SHALL both take effect, including with the FIFO full.
REQ-028 stall SHALL equal (occupancy >= DEPTH-1), registered-state based, so two same-cycle pushes never exceed capacity under compliant issue.
REQ-029 A push with no free slot (after same-cycle pop) SHALL be dropped and SHALL set lost; lost clears only on reset.
REQ-030 Read and write pointers SHALL wrap modulo DEPTH; occupancy SHALL be tracked separately to distinguish full from empty.

Reset
REQ-031 On reset low, asynchronously: FIFO empty, pointers 0, rs_valid 0, rs_data 0, stall 0, lost 0.
REQ-032 Reset asserted mid-handshake SHALL discard all pending entries; no write completes after deassertion until a new event.

Configuration
REQ-033 With macro RSTATUS_EXC_CNT_EN defined, the block SHALL add output exc_count [15:0], counting every accepted push (0, 1 or 2 per cycle), saturating at 16'hFFFF, reset to 0.
REQ-034 Without RSTATUS_EXC_CNT_EN, the port and counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-035 add overflow (op 0, alu 0, ex_ovf 1), rs_ready 1 -> rs_valid one cycle later, rs_data 2, rs_addr 30, popped same cycle.
REQ-036 Same cycle: addi ovf plus md_done, md_is_div 1, md_exc 1, rs_ready 0 -> queue holds 5 then 1; after releasing rs_ready, order 5, 1.
REQ-037 DEPTH 4, rs_ready 0, four sub overflows -> stall high at occupancy 3; fifth event -> dropped, lost 1, queue still 3,3,3,3.
REQ-038 sub overflow with flush 1 -> no push, rs_valid stays 0; and overflow with op 00010 -> no push.
REQ-039 Full FIFO, rs_ready 1 plus one new event -> pop and push both occur, occupancy stays 4, lost 0; with RSTATUS_EXC_CNT_EN, exc_count increments by accepted pushes only.
REQ-040 Reset pulsed low while rs_valid 1 -> rs_valid, rs_data, lost 0 immediately, without a clock edge.

Source files
------------

// File: rtl/rstatus_queue.sv
// Overflow/exception status queue feeding $rstatus writes to the register file.
// Optional exception counter output enabled by defining RSTATUS_EXC_CNT_EN.
module rstatus_queue #(
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 4,
   parameter int RS_ADDR = 30
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              ex_valid,
   input  logic [4:0]        ex_op,
   input  logic [4:0]        ex_alu_op,
   input  logic              ex_ovf,
   input  logic              flush,
   input  logic              md_done,
   input  logic              md_is_div,
   input  logic              md_exc,
   output logic              rs_valid,
   input  logic              rs_ready,
   output logic [4:0]        rs_addr,
   output logic [DATA_W-1:0] rs_data,
   output logic              stall,
   output logic              lost
`ifdef RSTATUS_EXC_CNT_EN
   ,
   output logic [15:0]       exc_count
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] ZERO_C  = CW'(0);
   localparam logic [CW-1:0] ONE_C   = CW'(1);
   localparam logic [CW-1:0] TWO_C   = CW'(2);

   logic [2:0]        mem_r [DEPTH];
   logic [PW-1:0]     rd_ptr_r;
   logic [PW-1:0]     wr_ptr_r;
   logic [CW-1:0]     count_r;
   logic              rs_valid_r;
   logic [DATA_W-1:0] rs_data_r;
   logic              stall_r;
   logic              lost_r;

   logic [2:0]    alu_code_s;
   logic          alu_ev_s;
   logic          md_ev_s;
   logic [2:0]    md_code_s;
   logic          p0_v_s;
   logic [2:0]    p0_code_s;
   logic          p1_v_s;
   logic [2:0]    p1_code_s;
   logic          pop_s;
   logic [CW-1:0] free_s;
   logic          acc0_s;
   logic          acc1_s;
   logic          drop_s;
   logic [CW-1:0] remain_s;
   logic [CW-1:0] count_next_s;
   logic [PW-1:0] rd_ptr_next_s;
   logic [PW-1:0] wr_ptr_next_s;
   logic [2:0]    head_next_s;

   // Decode the execute-stage instruction into an ALU overflow code (0 = none).
   always_comb begin
      alu_code_s = 3'd0;
      if (ex_op == 5'b00101) begin
         alu_code_s = 3'd1;
      end else if (ex_op == 5'b00000) begin
         case (ex_alu_op)
            5'b00000: alu_code_s = 3'd2;
            5'b00001: alu_code_s = 3'd3;
            default:  alu_code_s = 3'd0;
         endcase
      end else begin
         alu_code_s = 3'd0;
      end
   end

   assign alu_ev_s  = ex_valid & ex_ovf & ~flush & (alu_code_s != 3'd0);
   assign md_ev_s   = md_done & md_exc;
   assign md_code_s = md_is_div ? 3'd5 : 3'd4;

   // Order pushes (multdiv first), admit them against free space, compute next state.
   always_comb begin
      p0_v_s        = md_ev_s | alu_ev_s;
      p0_code_s     = md_ev_s ? md_code_s : alu_code_s;
      p1_v_s        = md_ev_s & alu_ev_s;
      p1_code_s     = alu_code_s;
      pop_s         = (count_r != ZERO_C) & rs_ready;
      free_s        = DEPTH_C - count_r + CW'(pop_s);
      acc0_s        = p0_v_s & (free_s >= ONE_C);
      acc1_s        = p1_v_s & (free_s >= TWO_C);
      drop_s        = (p0_v_s & ~acc0_s) | (p1_v_s & ~acc1_s);
      remain_s      = count_r - CW'(pop_s);
      count_next_s  = remain_s + CW'(acc0_s) + CW'(acc1_s);
      rd_ptr_next_s = rd_ptr_r + PW'(pop_s);
      wr_ptr_next_s = wr_ptr_r + PW'(acc0_s) + PW'(acc1_s);
      // An empty queue after the pop can only be refilled by this cycle's first push.
      if (remain_s != ZERO_C) begin
         head_next_s = mem_r[rd_ptr_next_s];
      end else if (acc0_s) begin
         head_next_s = p0_code_s;
      end else begin
         head_next_s = 3'd0;
      end
   end

   // Queue storage: write accepted pushes at the write pointer.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= 3'd0;
         end
      end else begin
         if (acc0_s) begin
            mem_r[wr_ptr_r] <= p0_code_s;
         end
         if (acc1_s) begin
            mem_r[wr_ptr_r + PW'(1)] <= p1_code_s;
         end
      end
   end

   // Pointers, occupancy and registered output view of the head.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_ptr_r   <= '0;
         wr_ptr_r   <= '0;
         count_r    <= '0;
         rs_valid_r <= 1'b0;
         rs_data_r  <= '0;
         stall_r    <= 1'b0;
         lost_r     <= 1'b0;
      end else begin
         rd_ptr_r   <= rd_ptr_next_s;
         wr_ptr_r   <= wr_ptr_next_s;
         count_r    <= count_next_s;
         rs_valid_r <= (count_next_s != ZERO_C);
         rs_data_r  <= DATA_W'(head_next_s);
         stall_r    <= (count_next_s >= (DEPTH_C - ONE_C));
         lost_r     <= lost_r | drop_s;
      end
   end

   assign rs_valid = rs_valid_r;
   assign rs_data  = rs_data_r;
   assign rs_addr  = 5'(RS_ADDR);
   assign stall    = stall_r;
   assign lost     = lost_r;

`ifdef RSTATUS_EXC_CNT_EN
   logic [15:0] exc_count_r;
   logic [16:0] exc_sum_s;

   assign exc_sum_s = {1'b0, exc_count_r} + 17'(acc0_s) + 17'(acc1_s);

   // Saturating count of accepted pushes.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         exc_count_r <= 16'h0000;
      end else if (exc_sum_s[16]) begin
         exc_count_r <= 16'hFFFF;
      end else begin
         exc_count_r <= exc_sum_s[15:0];
      end
   end

   assign exc_count = exc_count_r;
`endif

endmodule

// File: tb/tb_rstatus_queue.sv
// Scoreboard bench for rstatus_queue: stimulus queues expected codes, a
// negedge monitor checks every completed handshake in order.
module tb_rstatus_queue;

   logic        clock = 1'b0;
   logic        reset;
   logic        ex_valid;
   logic [4:0]  ex_op;
   logic [4:0]  ex_alu_op;
   logic        ex_ovf;
   logic        flush;
   logic        md_done;
   logic        md_is_div;
   logic        md_exc;
   logic        rs_valid;
   logic        rs_ready;
   logic [4:0]  rs_addr;
   logic [31:0] rs_data;
   logic        stall;
   logic        lost;
`ifdef RSTATUS_EXC_CNT_EN
   logic [15:0] exc_count;
`endif

   int n_vec = 0;
   int n_err = 0;
   logic [31:0] exp_q[$];

   rstatus_queue #(.DATA_W(32), .DEPTH(4), .RS_ADDR(30)) dut (
      .clock(clock), .reset(reset),
      .ex_valid(ex_valid), .ex_op(ex_op), .ex_alu_op(ex_alu_op), .ex_ovf(ex_ovf),
      .flush(flush), .md_done(md_done), .md_is_div(md_is_div), .md_exc(md_exc),
      .rs_valid(rs_valid), .rs_ready(rs_ready), .rs_addr(rs_addr), .rs_data(rs_data),
      .stall(stall), .lost(lost)
`ifdef RSTATUS_EXC_CNT_EN
      , .exc_count(exc_count)
`endif
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic clr();
      ex_valid = 1'b0; ex_op = 5'd0; ex_alu_op = 5'd0; ex_ovf = 1'b0; flush = 1'b0;
      md_done = 1'b0; md_is_div = 1'b0; md_exc = 1'b0;
   endtask

   task automatic alu_ovf(input logic [4:0] op, input logic [4:0] alu);
      ex_valid = 1'b1; ex_op = op; ex_alu_op = alu; ex_ovf = 1'b1;
   endtask

   // Monitor: every accepted status write must match the oldest expected code.
   always @(negedge clock) begin
      if (reset && rs_valid && rs_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", 32'd1, 32'd0);
         end else begin
            check("rs_data", rs_data, exp_q.pop_front());
            check("rs_addr", {27'd0, rs_addr}, 32'd30);
         end
      end
   end

   initial begin
      reset = 1'b0;
      rs_ready = 1'b0;
      clr();
      #3;
      check("rst_valid", {31'd0, rs_valid}, 32'd0);
      check("rst_data", rs_data, 32'd0);
      check("rst_stall", {31'd0, stall}, 32'd0);
      check("rst_lost", {31'd0, lost}, 32'd0);
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
      cyc();

      // add overflow, immediately accepted
      rs_ready = 1'b1;
      alu_ovf(5'b00000, 5'b00000); exp_q.push_back(32'd2);
      cyc(); clr();
      check("add_valid", {31'd0, rs_valid}, 32'd1);
      check("add_data", rs_data, 32'd2);
      cyc();
      check("add_drained", {31'd0, rs_valid}, 32'd0);

      // flushed sub and non-arithmetic op produce nothing
      alu_ovf(5'b00000, 5'b00001); flush = 1'b1;
      cyc(); clr();
      check("flush_nopush", {31'd0, rs_valid}, 32'd0);
      alu_ovf(5'b00010, 5'b00000);
      cyc(); clr();
      check("op2_nopush", {31'd0, rs_valid}, 32'd0);
      cyc();
      check("op2_nopush2", {31'd0, rs_valid}, 32'd0);

      // simultaneous addi overflow and div exception: div first
      rs_ready = 1'b0;
      alu_ovf(5'b00101, 5'b00000);
      md_done = 1'b1; md_is_div = 1'b1; md_exc = 1'b1;
      exp_q.push_back(32'd5); exp_q.push_back(32'd1);
      cyc(); clr();
      check("dual_head", rs_data, 32'd5);
      check("dual_stall", {31'd0, stall}, 32'd0);
      cyc(); cyc();
      check("dual_hold", rs_data, 32'd5);
      check("dual_hold_valid", {31'd0, rs_valid}, 32'd1);
      rs_ready = 1'b1;
      cyc();
      check("dual_next", rs_data, 32'd1);
      cyc();
      rs_ready = 1'b0;
      check("dual_empty", {31'd0, rs_valid}, 32'd0);

      // fill with four sub overflows
      for (int k = 1; k <= 4; k++) begin
         alu_ovf(5'b00000, 5'b00001); exp_q.push_back(32'd3);
         cyc(); clr();
         check("fill_stall", {31'd0, stall}, (k >= 3) ? 32'd1 : 32'd0);
      end
      check("fill_lost", {31'd0, lost}, 32'd0);

      // full queue: pop and push in the same cycle
      rs_ready = 1'b1;
      alu_ovf(5'b00101, 5'b00000); exp_q.push_back(32'd1);
      cyc(); clr();
      rs_ready = 1'b0;
      check("full_pp_lost", {31'd0, lost}, 32'd0);
      check("full_pp_stall", {31'd0, stall}, 32'd1);
      check("full_pp_valid", {31'd0, rs_valid}, 32'd1);

      // full queue, no pop: mult exception is dropped
      md_done = 1'b1; md_exc = 1'b1;
      cyc(); clr();
      check("drop_lost", {31'd0, lost}, 32'd1);
      check("drop_stall", {31'd0, stall}, 32'd1);
`ifdef RSTATUS_EXC_CNT_EN
      check("exc_count", {16'd0, exc_count}, 32'd8);
`endif
      rs_ready = 1'b1;
      repeat (4) cyc();
      rs_ready = 1'b0;
      check("drain_empty", {31'd0, rs_valid}, 32'd0);
      check("drain_stall", {31'd0, stall}, 32'd0);
      check("lost_sticky", {31'd0, lost}, 32'd1);

      // asynchronous reset mid-handshake
      alu_ovf(5'b00000, 5'b00000);
      cyc(); clr();
      check("pre_rst_valid", {31'd0, rs_valid}, 32'd1);
      #2 reset = 1'b0;
      exp_q.delete();
      #1;
      check("arst_valid", {31'd0, rs_valid}, 32'd0);
      check("arst_data", rs_data, 32'd0);
      check("arst_lost", {31'd0, lost}, 32'd0);
`ifdef RSTATUS_EXC_CNT_EN
      check("arst_count", {16'd0, exc_count}, 32'd0);
`endif
      cyc();
      reset = 1'b1;
      rs_ready = 1'b1;
      repeat (3) cyc();
      check("post_rst_idle", {31'd0, rs_valid}, 32'd0);
      check("sb_empty", exp_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
